banked_mem_arbiter: RTL
=======================

Name: banked_mem_arbiter

Overview:
Parametrised successor to the fixed IM/DM pairing. A single word-interleaved array of NUM_BANKS SRAM banks serves two CPU channels: instruction fetch (IF, read-only) and load/store (LS). Both channels use a valid/ready request handshake and receive tagged read responses after READ_LAT cycles. Per-bank conflicts favour LS, with a starvation guard for IF. The block sits between the CPU and the SRAM_wrapper instances.

Parameters:
NUM_BANKS, 4, bank count; power of two, 1..8
ADDR_W, 16, byte-address width on both channels
READ_LAT, 1, cycles from SRAM capture to rdata valid; 1..4
STARVE_LIMIT, 3, consecutive IF conflict losses before IF is forced to win; at least 1

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_req_valid  in  1  IF read request
if_req_ready  out  1  IF request accepted this cycle
if_req_addr  in  ADDR_W  IF byte address; [1:0] ignored
if_resp_valid  out  1  IF read data valid
if_resp_rdata  out  32  IF read data
ls_req_valid  in  1  LS request
ls_req_ready  out  1  LS request accepted this cycle
ls_req_addr  in  ADDR_W  LS byte address; [1:0] ignored
ls_req_wstrb  in  4  byte write enables, active-high; 0 means read
ls_req_wdata  in  32  write data
ls_resp_valid  out  1  LS read data valid
ls_resp_rdata  out  32  LS read data
bank_cs  out  NUM_BANKS  per-bank chip select
bank_oe  out  NUM_BANKS  per-bank output enable
bank_web  out  4*NUM_BANKS  per-bank byte write enables, active-low
bank_a  out  NUM_BANKS*ROW_W  per-bank row address
bank_di  out  32*NUM_BANKS  per-bank write data
bank_do  in  32*NUM_BANKS  per-bank read data
conflict_cnt  out  32  bank-conflict counter (see Optional Feature)

Behaviour:
- Clock is clk. Reset rst is synchronous and active-high.
- Address decode:
  - BANK_W = log2(NUM_BANKS); bank = addr[2+:BANK_W].
  - ROW_W = ADDR_W-2-BANK_W; row = addr[ADDR_W-1:2+BANK_W].
  - With NUM_BANKS=1, bank is always 0.
- Grant:
  - A channel is granted when its valid=1 and it wins its bank. Accept = valid && ready.
  - Different banks, or only one channel valid: both valid channels are granted in the same cycle.
  - Same bank, both valid (a conflict): LS wins, unless starve_cnt==STARVE_LIMIT, in which case IF wins.
- Ready:
  - ready is combinational and equals 0 only for the losing channel of a conflict.
  - An idle channel reads ready=1.
  - During rst=1, both readys are 0.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments on each IF conflict loss.
  - Clears on IF accept or rst.
  - Otherwise holds.
  - Never exceeds STARVE_LIMIT.
- Bank drive for a granted request:
  - cs=1; a=row.
  - Read: oe=1, web=4'hF.
  - LS write: oe=0, web=~wstrb, di=wdata.
- Idle bank: cs=0, oe=0, web=4'hF, a=0, di=0. All banks are idle while rst=1.
- Read response:
  - Each accepted read pushes {valid, bank} into a per-channel READ_LAT-deep shift pipeline.
  - resp_valid is asserted exactly READ_LAT cycles after accept.
  - resp_rdata = bank_do of the tagged bank at that cycle; it is 0 when resp_valid=0.
  - Back-to-back reads produce back-to-back responses, in order.
- Writes produce no response. Read-after-write to the same word in consecutive cycles returns the new data; ordering comes from the SRAM.
- Reset:
  - Pipelines, starve_cnt and conflict_cnt clear.
  - Both resp_valid are 0 from the cycle after rst is sampled high.
  - In-flight reads are discarded, never delivered.

Optional Feature:
MEM_ARB_STATS_EN
- Defined: conflict_cnt increments by 1 each cycle with a same-bank conflict (both valid); it saturates at 32'hFFFF_FFFF and clears on rst.
- Undefined: conflict_cnt is tied to 0 and no counter is synthesised.
- Arbitration is identical in both builds.

Decomposition:
- Package mem_arb_pkg: WORD_W=32, STRB_W=4, the bank/row extract functions, and the typedef rd_tag_t {logic vld; logic [BANK_W-1:0] bank}. Where the tag width depends on NUM_BANKS, the function is parametrised locally.
- Sub-module rd_resp_pipe: READ_LAT-deep tag shift register plus output data mux. Instantiated twice, once per channel.

Test Plan:
1. Reset, then IF read 0x0000 and LS read 0x0004 in the same cycle (banks 0 and 1) -> both ready=1; bank_cs=4'b0011; both resp_valid 1 cycle later with the preloaded words.
2. IF read 0x0010 and LS write 0x0000 with wstrb=4'b0011, wdata=0xAABBCCDD, both bank 0 -> ls_ready=1, if_ready=0; bank_web[3:0]=4'b1100; IF accepted next cycle; a later LS read 0x0000 returns only the low bytes updated.
3. Hold IF and LS on bank 2 continuously, STARVE_LIMIT=3 -> LS wins cycles 0-2, IF wins cycle 3, pattern repeats every 4 cycles; starve_cnt never exceeds 3.
4. READ_LAT=3, four back-to-back IF reads 0x0,0x4,0x8,0xC -> resp_valid high for 4 consecutive cycles starting 3 cycles after the first accept, data in order.
5. Assert rst while 2 LS reads are in flight -> no ls_resp_valid afterwards; all bank_cs=0; starve_cnt=0.
6. With MEM_ARB_STATS_EN, 5 conflict cycles -> conflict_cnt=5; the same stimulus built without the macro -> conflict_cnt=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants, read-tag type and address-decode helpers for banked_mem_arbiter.
package mem_arb_pkg;

  localparam int WORD_W     = 32;
  localparam int STRB_W     = 4;
  localparam int MAX_BANK_W = 3;

  // Bank field sized for the largest supported array (8 banks); smaller arrays zero-extend.
  typedef struct packed {
    logic                  vld;
    logic [MAX_BANK_W-1:0] bank;
  } rd_tag_t;

  function automatic logic [MAX_BANK_W-1:0] bank_of(input logic [31:0] addr,
                                                    input int unsigned num_banks);
    logic [31:0] b;
    b = (addr >> 2) & (num_banks - 1);
    return b[MAX_BANK_W-1:0];
  endfunction

  function automatic logic [31:0] row_of(input logic [31:0] addr,
                                         input int unsigned bank_w);
    return addr >> (2 + bank_w);
  endfunction

endpackage

// File: rtl/rd_resp_pipe.sv
// READ_LAT-deep read-tag shift register; the emerging tag selects the bank whose data is returned.
module rd_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int NUM_BANKS = 4,
  parameter int READ_LAT  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  rd_tag_t                     push,
  input  logic [WORD_W*NUM_BANKS-1:0] bank_do,
  output logic                        resp_valid,
  output logic [WORD_W-1:0]           resp_rdata
);

  rd_tag_t stage [READ_LAT];

  // NOTE: state registers use non-blocking assignments so every stage samples its
  // predecessor's pre-edge value; the tag stages are cleared on reset because an
  // in-flight read must never be delivered afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= push;
      for (int i = 1; i < READ_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // NOTE: outputs get defaults before the loop so no path through the block leaves
  // them unassigned, which would infer a latch.
  always_comb begin
    resp_valid = stage[READ_LAT-1].vld;
    resp_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (stage[READ_LAT-1].vld && stage[READ_LAT-1].bank == MAX_BANK_W'(b))
        resp_rdata = bank_do[b*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/banked_mem_arbiter.sv
// Two-channel (IF read-only, LS read/write) arbiter over a word-interleaved SRAM bank array.
// Optional conflict statistics counter enabled by defining MEM_ARB_STATS_EN.
module banked_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_BANKS    = 4,
  parameter int  ADDR_W       = 16,
  parameter int  READ_LAT     = 1,
  parameter int  STARVE_LIMIT = 3,
  localparam int BANK_W       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0,
  localparam int ROW_W        = ADDR_W - 2 - BANK_W,
  localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        if_req_valid,
  output logic                        if_req_ready,
  input  logic [ADDR_W-1:0]           if_req_addr,
  output logic                        if_resp_valid,
  output logic [WORD_W-1:0]           if_resp_rdata,
  input  logic                        ls_req_valid,
  output logic                        ls_req_ready,
  input  logic [ADDR_W-1:0]           ls_req_addr,
  input  logic [STRB_W-1:0]           ls_req_wstrb,
  input  logic [WORD_W-1:0]           ls_req_wdata,
  output logic                        ls_resp_valid,
  output logic [WORD_W-1:0]           ls_resp_rdata,
  output logic [NUM_BANKS-1:0]        bank_cs,
  output logic [NUM_BANKS-1:0]        bank_oe,
  output logic [STRB_W*NUM_BANKS-1:0] bank_web,
  output logic [NUM_BANKS*ROW_W-1:0]  bank_a,
  output logic [WORD_W*NUM_BANKS-1:0] bank_di,
  input  logic [WORD_W*NUM_BANKS-1:0] bank_do,
  output logic [31:0]                 conflict_cnt
);

  logic [MAX_BANK_W-1:0] if_bank, ls_bank;
  logic [ROW_W-1:0]      if_row, ls_row;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  conflict, if_forced, if_acc, ls_acc, ls_rd;
  rd_tag_t               if_tag, ls_tag;

  always_comb begin
    if_bank      = bank_of(32'(if_req_addr), NUM_BANKS);
    ls_bank      = bank_of(32'(ls_req_addr), NUM_BANKS);
    if_row       = ROW_W'(row_of(32'(if_req_addr), BANK_W));
    ls_row       = ROW_W'(row_of(32'(ls_req_addr), BANK_W));
    conflict     = if_req_valid && ls_req_valid && (if_bank == ls_bank);
    if_forced    = (starve_cnt == STARVE_W'(STARVE_LIMIT));
    if_req_ready = !rst && !(conflict && !if_forced);
    ls_req_ready = !rst && !(conflict && if_forced);
    if_acc       = if_req_valid && if_req_ready;
    ls_acc       = ls_req_valid && ls_req_ready;
    ls_rd        = ls_acc && (ls_req_wstrb == '0);
    if_tag       = '{vld: if_acc, bank: if_bank};
    ls_tag       = '{vld: ls_rd, bank: ls_bank};
  end

  // An IF conflict loss can only occur below the limit, so the counter saturates naturally.
  always_ff @(posedge clk) begin
    if (rst)           starve_cnt <= '0;
    else if (if_acc)   starve_cnt <= '0;
    else if (conflict) starve_cnt <= starve_cnt + 1'b1;
  end

  always_comb begin
    bank_cs  = '0;
    bank_oe  = '0;
    bank_web = '1;
    bank_a   = '0;
    bank_di  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (ls_acc && ls_bank == MAX_BANK_W'(b)) begin
        bank_cs[b]               = 1'b1;
        bank_a[b*ROW_W +: ROW_W] = ls_row;
        if (ls_rd) begin
          bank_oe[b] = 1'b1;
        end else begin
          bank_web[b*STRB_W +: STRB_W] = ~ls_req_wstrb;
          bank_di[b*WORD_W +: WORD_W]  = ls_req_wdata;
        end
      end else if (if_acc && if_bank == MAX_BANK_W'(b)) begin
        bank_cs[b]               = 1'b1;
        bank_oe[b]               = 1'b1;
        bank_a[b*ROW_W +: ROW_W] = if_row;
      end
    end
  end

  rd_resp_pipe #(
    .NUM_BANKS(NUM_BANKS),
    .READ_LAT (READ_LAT)
  ) u_if_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (if_tag),
    .bank_do   (bank_do),
    .resp_valid(if_resp_valid),
    .resp_rdata(if_resp_rdata)
  );

  rd_resp_pipe #(
    .NUM_BANKS(NUM_BANKS),
    .READ_LAT (READ_LAT)
  ) u_ls_pipe (
    .clk       (clk),
    .rst       (rst),
    .push      (ls_tag),
    .bank_do   (bank_do),
    .resp_valid(ls_resp_valid),
    .resp_rdata(ls_resp_rdata)
  );

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)                               conflict_cnt <= '0;
    else if (conflict && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 32'd1;
  end
`else
  assign conflict_cnt = '0;
`endif

endmodule
